// File: rtl/float_two_power_pipe.sv
// float_two_power_pipe: three-stage pipelined c = 2^a for parameterised IEEE-754 floats.
// Optional feature macro FLOAT_POW2_FRAC_EN adds the interpolated 2^frac(a) mantissa; without it c = 2^floor(a).

module float_two_power_pipe #(
   parameter int EXP_W    = 8,
   parameter int MAN_W    = 23,
   parameter int LUT_BITS = 6
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W+MAN_W:0] a,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [EXP_W+MAN_W:0] c,
   output logic [2:0]           out_flags
);

   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int IW = EXP_W + 2;
   localparam int MW = IW + MAN_W;
   localparam logic signed [IW-1:0] BIAS_S = IW'((1 << (EXP_W - 1)) - 1);
   localparam logic signed [IW-1:0] UE_SAT = IW'(EXP_W);
   localparam logic signed [IW-1:0] EMAX_S = IW'((1 << EXP_W) - 1);
   localparam logic [W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   if (LUT_BITS < 1 || LUT_BITS >= MAN_W) begin : g_bad_lut_bits
      $error("float_two_power_pipe: LUT_BITS must lie in 1..MAN_W-1");
   end

   logic                 w_sign, w_nan, w_inf, w_zero, w_frac_nz, w_advance;
   logic [EXP_W-1:0]     w_exp;
   logic [MAN_W-1:0]     w_man, w_mag_f, w_m;
   logic signed [IW-1:0] w_ue, w_i, w_e;
   logic [IW-1:0]        w_shr, w_mag_i;
   logic [MW-1:0]        w_full, w_mag;
   logic [W-1:0]         w_c;
   logic [2:0]           w_flags;

   logic                 r1_valid, r1_nan, r1_pinf, r1_ninf;
   logic signed [IW-1:0] r1_i;
   logic                 r2_valid, r2_nan, r2_pinf, r2_ninf;
   logic signed [IW-1:0] r2_e;
   logic [MAN_W-1:0]     r2_m;

   // Handshake: a word transfers on a clock edge where valid && ready. All
   // three stages move together whenever the output slot is empty or being
   // drained, so nothing is dropped and c/out_flags hold during a stall.
   assign w_advance = !out_valid || out_ready;
   assign in_ready  = rstn && w_advance;

   assign {w_sign, w_exp, w_man} = a;
   assign w_nan  = (&w_exp) && (|w_man);
   assign w_inf  = (&w_exp) && !(|w_man);
   assign w_zero = (w_exp == '0);
   assign w_ue   = $signed({2'b00, w_exp}) - BIAS_S;
   assign w_shr  = -w_ue;
   assign w_full = {{(IW-1){1'b0}}, 1'b1, w_man};

   // |a| as unsigned fixed point with MAN_W fraction bits, saturated at 2^EXP_W
   always_comb begin
      w_mag = '0;
      if (!w_zero && !(&w_exp)) begin
         if (w_ue >= UE_SAT)
            w_mag[MAN_W+EXP_W] = 1'b1;
         else if (!w_ue[IW-1])
            w_mag = w_full << w_ue;
         else
            w_mag = w_full >> w_shr;
      end
   end

   assign w_mag_i   = w_mag[MW-1:MAN_W];
   assign w_mag_f   = w_mag[MAN_W-1:0];
   assign w_frac_nz = |w_mag_f;
   // Floor for negatives: a non-zero fraction pushes I down by one
   assign w_i = w_sign ? -(w_mag_i + IW'(w_frac_nz)) : w_mag_i;
   assign w_e = r1_i + BIAS_S;

`ifdef FLOAT_POW2_FRAC_EN
   localparam int N  = 1 << LUT_BITS;
   localparam int RB = MAN_W - LUT_BITS;
   localparam int TW = MAN_W + 2;

   function automatic logic [TW-1:0] tab_entry(input int k);
      real x;
      x = (2.0 ** (real'(k) / real'(N)) - 1.0) * (2.0 ** MAN_W);
      return TW'($rtoi(x + 0.5));
   endfunction

   logic [MAN_W-1:0]   w_f, r1_f;
   logic [TW-1:0]      w_tab [0:N];
   logic [LUT_BITS:0]  w_k0, w_k1;
   logic [RB-1:0]      w_r;
   logic [TW-1:0]      w_t0, w_t1, w_sum;
   logic [TW+RB-1:0]   w_prod;

   assign w_f = (w_sign && w_frac_nz) ? -w_mag_f : w_mag_f;

   for (genvar g = 0; g <= N; g++) begin : g_tab
      localparam logic [TW-1:0] TV = tab_entry(g);
      assign w_tab[g] = TV;
   end

   assign w_k0   = {1'b0, r1_f[MAN_W-1 -: LUT_BITS]};
   assign w_k1   = w_k0 + (LUT_BITS+1)'(1);
   assign w_r    = r1_f[RB-1:0];
   assign w_t0   = w_tab[w_k0];
   assign w_t1   = w_tab[w_k1];
   assign w_prod = (TW+RB)'(w_t1 - w_t0) * (TW+RB)'(w_r);
   assign w_sum  = w_t0 + w_prod[RB +: TW];
   assign w_m    = w_sum[MAN_W-1:0];
`else
   assign w_m = '0;
`endif

   // Output packing; specials take priority over range checks
   always_comb begin
      w_c     = {1'b0, r2_e[EXP_W-1:0], r2_m};
      w_flags = 3'b000;
      if (r2_nan) begin
         w_c     = QNAN;
         w_flags = 3'b100;
      end else if (r2_pinf) begin
         w_c = PINF;
      end else if (r2_ninf) begin
         w_c = '0;
      end else if (r2_e >= EMAX_S) begin
         w_c     = PINF;
         w_flags = 3'b010;
      end else if (r2_e[IW-1] || (r2_e == '0)) begin
         w_c     = '0;
         w_flags = 3'b001;
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         r1_valid  <= 1'b0;
         r1_nan    <= 1'b0;
         r1_pinf   <= 1'b0;
         r1_ninf   <= 1'b0;
         r1_i      <= '0;
         r2_valid  <= 1'b0;
         r2_nan    <= 1'b0;
         r2_pinf   <= 1'b0;
         r2_ninf   <= 1'b0;
         r2_e      <= '0;
         r2_m      <= '0;
         out_valid <= 1'b0;
         c         <= '0;
         out_flags <= 3'b000;
`ifdef FLOAT_POW2_FRAC_EN
         r1_f      <= '0;
`endif
      end else if (w_advance) begin
         r1_valid  <= in_valid;
         r1_nan    <= w_nan;
         r1_pinf   <= w_inf && !w_sign;
         r1_ninf   <= w_inf && w_sign;
         r1_i      <= w_i;
         r2_valid  <= r1_valid;
         r2_nan    <= r1_nan;
         r2_pinf   <= r1_pinf;
         r2_ninf   <= r1_ninf;
         r2_e      <= w_e;
         r2_m      <= w_m;
         out_valid <= r2_valid;
         c         <= w_c;
         out_flags <= w_flags;
`ifdef FLOAT_POW2_FRAC_EN
         r1_f      <= w_f;
`endif
      end
   end

endmodule

// File: tb/tb_float_two_power_pipe.sv
// Testbench for float_two_power_pipe at single precision: directed table, backpressure,
// reset-flush sequences and random traffic scored against a real-arithmetic model.

module tb_float_two_power_pipe;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  c;
   logic [2:0]    out_flags;

   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_out    = 0;
   logic [W+2:0]  exp_q[$];

   typedef struct {
      logic [31:0] a;
      logic [31:0] c;
      logic [2:0]  f;
   } vec_t;

   vec_t tbl [17];

   float_two_power_pipe dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .c         (c),
      .out_flags (out_flags)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, required finish before 400000");
      $fatal(1, "watchdog");
   end

   // Reference: real arithmetic on the decoded value, floor split, then range rules
   function automatic logic [W+2:0] model(input logic [31:0] x);
      int ex, mn, e, m;
      real mag, v, ip, f;
      logic [7:0]  e8;
      logic [22:0] m23;
      ex = int'(x[30:23]);
      mn = int'(x[22:0]);
      if (ex == 255) begin
         if (mn != 0) return {3'b100, 32'h7FC00000};
         if (x[31]) return {3'b000, 32'h00000000};
         return {3'b000, 32'h7F800000};
      end
      if (ex == 0) return {3'b000, 32'h3F800000};
      mag = (1.0 + real'(mn) / 8388608.0) * (2.0 ** real'(ex - 127));
      mag = $floor(mag * 8388608.0) / 8388608.0;
      v   = x[31] ? -mag : mag;
      ip  = $floor(v);
      f   = v - ip;
      if (ip >= 128.0) return {3'b010, 32'h7F800000};
      if (ip <= -127.0) return {3'b001, 32'h00000000};
      e = $rtoi(ip) + 127;
`ifdef FLOAT_POW2_FRAC_EN
      m = $rtoi($floor((2.0 ** f - 1.0) * 8388608.0));
`else
      m = 0;
`endif
      e8  = e[7:0];
      m23 = m[22:0];
      return {3'b000, 1'b0, e8, m23};
   endfunction

   function automatic bit res_ok(input logic [W+2:0] got, input logic [W+2:0] want);
`ifdef FLOAT_POW2_FRAC_EN
      int gm, wm, d;
      if (got[W+2:23] !== want[W+2:23]) return 1'b0;
      gm = int'(got[22:0]);
      wm = int'(want[22:0]);
      d  = (gm > wm) ? gm - wm : wm - gm;
      return d <= 260 + (wm >>> 15);
`else
      return got === want;
`endif
   endfunction

   task automatic check_val(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h", nm, got, want);
      end
   endtask

   task automatic check_res(input string nm, input logic [W+2:0] got, input logic [W+2:0] want);
      n_checks++;
      if (!res_ok(got, want)) begin
         n_fail++;
         $display("FAIL %s: got flags=%b c=%h, required flags=%b c=%h",
                  nm, got[W+2:W], got[W-1:0], want[W+2:W], want[W-1:0]);
      end
   endtask

   // Scoreboard: pop before push so a spurious output never matches a fresh input
   logic          stall_prev = 1'b0;
   logic [W+2:0]  held;
   always @(negedge clk) begin
      if (!rstn) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) check_val("hold_stable", {out_flags, c}, held);
         if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_output: got c=%h with nothing outstanding, required no output", c);
            end else begin
               check_res("stream", {out_flags, c}, exp_q.pop_front());
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a));
         stall_prev = out_valid && !out_ready;
         held       = {out_flags, c};
      end
   end

   // Drivers: called at posedge+1; send leaves in_valid high after acceptance
   task automatic send(input logic [31:0] x);
      bit got;
      int k;
      in_valid = 1'b1;
      a        = x;
      got      = 1'b0;
      k        = 0;
      while (!got && k < 100) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         k++;
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1");
      end
   endtask

   task automatic wait_out(output logic [W+2:0] r, output int lat);
      lat = 1;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
      r = {out_flags, c};
   endtask

   task automatic drain(input string nm);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || out_valid) && k < 60) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_val(nm, 64'(exp_q.size()), 64'd0);
   endtask

   function automatic logic [31:0] rand_float();
      logic [31:0] x;
      int ex, sh;
      x = $urandom;
      case ($urandom_range(0, 9))
         0: begin
            case ($urandom_range(0, 4))
               0:       x = {x[31], 8'hFF, x[22:1], 1'b1};
               1:       x = {1'b0, 8'hFF, 23'h0};
               2:       x = {1'b1, 8'hFF, 23'h0};
               3:       x = {x[31], 8'h00, x[22:0]};
               default: x = {x[31], 31'h0};
            endcase
         end
         1: begin
            ex = $urandom_range(127, 134);
            sh = 23 - (ex - 127);
            x[30:23] = 8'(ex);
            x[22:0]  = (x[22:0] >> sh) << sh;
         end
         2:       x[30:23] = 8'($urandom_range(1, 254));
         default: x[30:23] = 8'($urandom_range(100, 140));
      endcase
      return x;
   endfunction

   initial begin
      logic [W+2:0] r;
      int           lat, base;
      bit           acc_prev;

`ifdef FLOAT_POW2_FRAC_EN
      tbl[1]  = '{32'hC0200000, 32'h3E3504F3, 3'b000};
      tbl[13] = '{32'h3F000000, 32'h3FB504F3, 3'b000};
      tbl[16] = '{32'hBFC00000, 32'h3EB504F3, 3'b000};
`else
      tbl[1]  = '{32'hC0200000, 32'h3E000000, 3'b000};
      tbl[13] = '{32'h3F000000, 32'h3F800000, 3'b000};
      tbl[16] = '{32'hBFC00000, 32'h3E800000, 3'b000};
`endif
      tbl[0]  = '{32'h40400000, 32'h41000000, 3'b000};
      tbl[2]  = '{32'h43000000, 32'h7F800000, 3'b010};
      tbl[3]  = '{32'hC2FC0000, 32'h00800000, 3'b000};
      tbl[4]  = '{32'hC2FE0000, 32'h00000000, 3'b001};
      tbl[5]  = '{32'h7FC00001, 32'h7FC00000, 3'b100};
      tbl[6]  = '{32'hFF800000, 32'h00000000, 3'b000};
      tbl[7]  = '{32'h00000001, 32'h3F800000, 3'b000};
      tbl[8]  = '{32'h7F800000, 32'h7F800000, 3'b000};
      tbl[9]  = '{32'h3F800000, 32'h40000000, 3'b000};
      tbl[10] = '{32'hBF800000, 32'h3F000000, 3'b000};
      tbl[11] = '{32'h80000000, 32'h3F800000, 3'b000};
      tbl[12] = '{32'h42FE0000, 32'h7F000000, 3'b000};
      tbl[14] = '{32'h7F7FFFFF, 32'h7F800000, 3'b010};
      tbl[15] = '{32'hFF7FFFFF, 32'h00000000, 3'b001};

      // Reset: outputs cleared and no acceptance even with in_valid high
      rstn      = 1'b0;
      in_valid  = 1'b1;
      a         = 32'h40400000;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_c", c, 0);
      check_val("rst_flags", out_flags, 0);
      check_val("rst_in_ready", in_ready, 0);
      in_valid = 1'b0;
      rstn     = 1'b1;
      @(posedge clk);
      #1;

      // Directed table, one item at a time with latency measured from the accept cycle
      for (int i = 0; i < 17; i++) begin
         send(tbl[i].a);
         in_valid = 1'b0;
         wait_out(r, lat);
         check_val($sformatf("lat_%0d", i), 64'(lat), 64'd3);
         check_res($sformatf("vec_%0d_a_%h", i, tbl[i].a), r, {tbl[i].f, tbl[i].c});
      end
      drain("tbl_drain");

      // Backpressure: three accepts fill the pipe, fourth waits, order preserved
      base      = n_out;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         a        = 32'h3F800000 + (32'(i) << 23);
         if (i == 2) a = 32'h40400000;
         @(negedge clk);
         check_val($sformatf("bp_accept_%0d", i), in_ready, 1);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      a        = 32'h40800000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_val($sformatf("bp_full_%0d", i), in_ready, 0);
         check_val($sformatf("bp_out_valid_%0d", i), out_valid, 1);
         check_val($sformatf("bp_head_%0d", i), c, 32'h40000000);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_val("bp_release", in_ready, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain("bp_drain");
      check_val("bp_count", 64'(n_out - base), 64'd4);

      // Reset with two items in flight: both dropped, pipe restarts cleanly
      send(32'h3F800000);
      send(32'h40000000);
      in_valid = 1'b0;
      rstn     = 1'b0;
      @(posedge clk);
      #1;
      check_val("rst_mid_out_valid", out_valid, 0);
      check_val("rst_mid_in_ready", in_ready, 0);
      rstn = 1'b1;
      base = n_out;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check_val($sformatf("rst_no_ghost_%0d", i), out_valid, 0);
      end
      check_val("rst_no_ghost_count", 64'(n_out - base), 64'd0);
      send(32'h41000000);
      in_valid = 1'b0;
      wait_out(r, lat);
      check_val("rst_new_lat", 64'(lat), 64'd3);
      check_res("rst_new_res", r, {3'b000, 32'h43800000});
      drain("rst_drain");

      // Random traffic with random backpressure; valid held until accepted
      acc_prev = 1'b0;
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (!in_valid || acc_prev) begin
            in_valid = ($urandom_range(0, 3) != 0);
            a        = rand_float();
         end
         out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc_prev = in_valid && in_ready;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
